// File: rtl/dac_spi_channel_model.sv
// dac_spi_channel_model
//   Behavioural, synthesizable model of a multi-channel SPI DAC with
//   input/DAC double-buffering, per-channel power-down and a daisy-chain
//   echo output. Frames are 32 bits (optionally 24), MSB first.
//
// Ports
//   SPI_SCK   in   serial clock; MOSI sampled on rise, DAC_OUT moves on fall
//   DAC_CLR   in   asynchronous active-low clear
//   DAC_CS    in   active-low frame select
//   SPI_MOSI  in   serial data in
//   DAC_OUT   out  echo of the previously accepted frame, MSB first
//   dac_code  out  DAC register of channel k at [k*DATA_W +: DATA_W]
//   pd_mask   out  per-channel power-down flags
//   frame_cnt out  accepted frame count (wraps)
//   err_cnt   out  rejected frame count (saturates at 255)
//   last_cmd  out  command field of the last accepted frame
//   last_addr out  address field of the last accepted frame
module dac_spi_channel_model #(
  parameter int NCH      = 4,
  parameter int DATA_W   = 12,
  parameter bit ALLOW_24 = 1'b0
) (
  input  logic                    SPI_SCK,
  input  logic                    DAC_CLR,
  input  logic                    DAC_CS,
  input  logic                    SPI_MOSI,
  output logic                    DAC_OUT,
  output logic [NCH*DATA_W-1:0]   dac_code,
  output logic [NCH-1:0]          pd_mask,
  output logic [15:0]             frame_cnt,
  output logic [7:0]              err_cnt,
  output logic [3:0]              last_cmd,
  output logic [3:0]              last_addr
);

  // Frame-start domain (falling DAC_CS)
  logic        armed_q;
  logic        gen_bit_q;   // differs from gen_sck_q until the first SCK rise of a frame
  logic        gen_eo_q;    // differs from gen_echo_q until the first SCK fall of a frame

  // Shift domain (rising SPI_SCK)
  logic [31:0] sr_q;
  logic [5:0]  bcnt_q;
  logic        gen_sck_q;

  // Echo domain (falling SPI_SCK)
  logic [31:0] echo_q;
  logic        gen_echo_q;

  // Frame-close domain (rising DAC_CS)
  logic [DATA_W-1:0] in_q  [NCH];
  logic [DATA_W-1:0] dac_q [NCH];
  logic [DATA_W-1:0] in_d  [NCH];
  logic [DATA_W-1:0] dac_d [NCH];
  logic [NCH-1:0]    pd_q, pd_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [7:0]        err_q, err_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [3:0]        addr_q, addr_d;
  logic [31:0]       lword_q, lword_d;

  logic [5:0]        nbits;
  logic              len_ok;
  logic [31:0]       word;
  logic [3:0]        cmd_w, addr_w;
  logic [DATA_W-1:0] data_w;
  logic              addr_ok;
  logic [NCH-1:0]    sel;
  logic              echo_msb;

  // Frame start: the generation flags are set to the complement of what the
  // SCK domains last saw, so the first edge of every frame is recognised
  // even when the previous frame had no clock edges at all.
  always_ff @(negedge DAC_CS or negedge DAC_CLR) begin
    if (!DAC_CLR) begin
      armed_q   <= 1'b0;
      gen_bit_q <= 1'b0;
      gen_eo_q  <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      gen_bit_q <= ~gen_sck_q;
      gen_eo_q  <= ~gen_echo_q;
    end
  end

  // Shift in on rising SCK; the first edge of a frame restarts the count.
  always_ff @(posedge SPI_SCK or negedge DAC_CLR) begin
    if (!DAC_CLR) begin
      sr_q      <= '0;
      bcnt_q    <= '0;
      gen_sck_q <= 1'b0;
    end else if (!DAC_CS && armed_q) begin
      sr_q <= {sr_q[30:0], SPI_MOSI};
      if (gen_sck_q != gen_bit_q) begin
        bcnt_q    <= 6'd1;
        gen_sck_q <= gen_bit_q;
      end else if (bcnt_q != 6'd63) begin
        bcnt_q <= bcnt_q + 6'd1;
      end
    end
  end

  // Echo shifts on falling SCK; the first fall of a frame shifts the
  // freshly loaded copy of the last accepted word.
  always_ff @(negedge SPI_SCK or negedge DAC_CLR) begin
    if (!DAC_CLR) begin
      echo_q     <= '0;
      gen_echo_q <= 1'b0;
    end else if (!DAC_CS && armed_q) begin
      if (gen_echo_q != gen_eo_q) begin
        echo_q     <= {lword_q[30:0], 1'b0};
        gen_echo_q <= gen_eo_q;
      end else begin
        echo_q <= {echo_q[30:0], 1'b0};
      end
    end
  end

  // Before the first SCK fall the echo register logically holds lword_q.
  assign echo_msb = (gen_echo_q != gen_eo_q) ? lword_q[31] : echo_q[31];
  assign DAC_OUT  = DAC_CLR && !DAC_CS && armed_q && echo_msb;

  // Frame decode. A frame with no SCK rise leaves a stale bcnt_q behind,
  // so its length is taken as zero.
  always_comb begin
    nbits   = (gen_sck_q == gen_bit_q) ? bcnt_q : 6'd0;
    len_ok  = (nbits == 6'd32) || (ALLOW_24 && (nbits == 6'd24));
    word    = (nbits == 6'd24) ? {8'h00, sr_q[23:0]} : sr_q;
    cmd_w   = word[23:20];
    addr_w  = word[19:16];
    data_w  = word[15 -: DATA_W];
    addr_ok = (addr_w == 4'hF) || (int'(addr_w) < NCH);
    sel     = '0;
    for (int k = 0; k < NCH; k++) begin
      sel[k] = (addr_w == 4'hF) || (int'(addr_w) == k);
    end
  end

  always_comb begin
    in_d    = in_q;
    dac_d   = dac_q;
    pd_d    = pd_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    lword_d = lword_q;
    if (armed_q) begin
      if (len_ok) begin
        fcnt_d  = fcnt_q + 16'd1;
        cmd_d   = cmd_w;
        addr_d  = addr_w;
        lword_d = word;
        if (addr_ok) begin
          for (int k = 0; k < NCH; k++) begin
            case (cmd_w)
              4'b0000: if (sel[k]) in_d[k] = data_w;
              4'b0001: if (sel[k]) begin
                dac_d[k] = in_q[k];
                pd_d[k]  = 1'b0;
              end
              4'b0010: begin
                // Every channel loads its input register; the addressed
                // ones see the new data in the same frame.
                if (sel[k]) begin
                  in_d[k]  = data_w;
                  dac_d[k] = data_w;
                end else begin
                  dac_d[k] = in_q[k];
                end
                pd_d[k] = 1'b0;
              end
              4'b0011: if (sel[k]) begin
                in_d[k]  = data_w;
                dac_d[k] = data_w;
                pd_d[k]  = 1'b0;
              end
              4'b0100: if (sel[k]) pd_d[k] = 1'b1;
              default: ;
            endcase
          end
        end
      end else if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
    end
  end

  always_ff @(posedge DAC_CS or negedge DAC_CLR) begin
    if (!DAC_CLR) begin
      in_q    <= '{default: '0};
      dac_q   <= '{default: '0};
      pd_q    <= '0;
      fcnt_q  <= '0;
      err_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      lword_q <= '0;
    end else begin
      in_q    <= in_d;
      dac_q   <= dac_d;
      pd_q    <= pd_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      lword_q <= lword_d;
    end
  end

  // Powered-down channels read as zero; the stored code is kept.
  always_comb begin
    dac_code = '0;
    for (int k = 0; k < NCH; k++) begin
      dac_code[k*DATA_W +: DATA_W] = pd_q[k] ? '0 : dac_q[k];
    end
  end

  assign pd_mask   = pd_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt   = err_q;
  assign last_cmd  = cmd_q;
  assign last_addr = addr_q;

endmodule

// File: tb/tb_dac_spi_channel_model.sv
module tb_dac_spi_channel_model;

  logic        SPI_SCK, DAC_CLR, DAC_CS, SPI_MOSI;
  logic        DAC_OUT0, DAC_OUT1;
  logic [47:0] code0, code1;
  logic [3:0]  pd0, pd1;
  logic [15:0] fcnt0, fcnt1;
  logic [7:0]  err0, err1;
  logic [3:0]  cmd0, cmd1, addr0, addr1;

  int checks = 0;
  int errors = 0;
  logic [31:0] cap0, cap1;

  dac_spi_channel_model #(.NCH(4), .DATA_W(12), .ALLOW_24(1'b0)) u_dut0 (
    .SPI_SCK(SPI_SCK), .DAC_CLR(DAC_CLR), .DAC_CS(DAC_CS), .SPI_MOSI(SPI_MOSI),
    .DAC_OUT(DAC_OUT0), .dac_code(code0), .pd_mask(pd0), .frame_cnt(fcnt0),
    .err_cnt(err0), .last_cmd(cmd0), .last_addr(addr0)
  );

  dac_spi_channel_model #(.NCH(4), .DATA_W(12), .ALLOW_24(1'b1)) u_dut1 (
    .SPI_SCK(SPI_SCK), .DAC_CLR(DAC_CLR), .DAC_CS(DAC_CS), .SPI_MOSI(SPI_MOSI),
    .DAC_OUT(DAC_OUT1), .dac_code(code1), .pd_mask(pd1), .frame_cnt(fcnt1),
    .err_cnt(err1), .last_cmd(cmd1), .last_addr(addr1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Sends nbits bits MSB first; bits above 31 are sent as 0. Captures the
  // first 32 DAC_OUT bits of both instances just before each rising SCK.
  task automatic send(input logic [31:0] w, input int nbits);
    logic [31:0] wv;
    wv   = w;
    cap0 = '0;
    cap1 = '0;
    DAC_CS = 1'b0;
    #5;
    for (int i = nbits - 1; i >= 0; i--) begin
      SPI_MOSI = (i < 32) ? wv[i] : 1'b0;
      #5;
      if (nbits - 1 - i < 32) begin
        cap0 = {cap0[30:0], DAC_OUT0};
        cap1 = {cap1[30:0], DAC_OUT1};
      end
      SPI_SCK = 1'b1;
      #5;
      SPI_SCK = 1'b0;
    end
    #5;
    DAC_CS = 1'b1;
    #10;
  endtask

  task automatic clr_pulse();
    DAC_CLR = 1'b0;
    #5;
    chk("clr_out_low", {63'd0, DAC_OUT0}, 64'd0);
    chk("clr_code_low", {16'd0, code0}, 64'd0);
    DAC_CLR = 1'b1;
    #5;
  endtask

  initial begin
    DAC_CLR  = 1'b0;
    DAC_CS   = 1'b1;
    SPI_SCK  = 1'b0;
    SPI_MOSI = 1'b0;
    #20;
    chk("rst_code", {16'd0, code0}, 64'd0);
    chk("rst_pd", {60'd0, pd0}, 64'd0);
    chk("rst_fcnt", {48'd0, fcnt0}, 64'd0);
    chk("rst_err", {56'd0, err0}, 64'd0);
    chk("rst_out", {63'd0, DAC_OUT0}, 64'd0);
    DAC_CLR = 1'b1;
    #10;

    // SCK while CS high must be ignored
    for (int i = 0; i < 5; i++) begin
      SPI_SCK = 1'b1; #5; SPI_SCK = 1'b0; #5;
    end

    send(32'h0032ABC0, 32);
    chk("wr_upd_code", {16'd0, code0}, 64'h000ABC000000);
    chk("wr_upd_fcnt", {48'd0, fcnt0}, 64'd1);
    chk("wr_upd_cmd", {56'd0, cmd0, addr0}, 64'h32);
    chk("idle_out", {63'd0, DAC_OUT0}, 64'd0);

    send(32'h00011230, 32);
    chk("stage_ch1_hold", {16'd0, code0}, 64'h000ABC000000);
    send(32'h00110000, 32);
    chk("stage_ch1_upd", {16'd0, code0}, 64'h000ABC123000);
    chk("stage_fcnt", {48'd0, fcnt0}, 64'd3);
    chk("echo_a", {32'd0, cap0}, {32'd0, 32'h00011230});

    send(32'h00202220, 32);
    chk("cmd2_all", {16'd0, code0}, 64'h000ABC123222);
    chk("echo_b", {32'd0, cap0}, {32'd0, 32'h00110000});

    send(32'h003F7FF0, 32);
    chk("bc_write", {16'd0, code0}, 64'h7FF7FF7FF7FF);
    send(32'h004F0000, 32);
    chk("bc_pd_code", {16'd0, code0}, 64'd0);
    chk("bc_pd_mask", {60'd0, pd0}, 64'hF);
    send(32'h00100000, 32);
    chk("pd_clr_code", {16'd0, code0}, 64'h0000000007FF);
    chk("pd_clr_mask", {60'd0, pd0}, 64'hE);
    chk("pd_clr_fcnt", {48'd0, fcnt0}, 64'd7);

    send(32'h00355550, 32);
    chk("bad_addr_code", {16'd0, code0}, 64'h0000000007FF);
    chk("bad_addr_fcnt", {48'd0, fcnt0}, 64'd8);
    send(32'h00F0AAA0, 32);
    chk("nop_code", {16'd0, code0}, 64'h0000000007FF);
    chk("nop_fields", {48'd0, fcnt0, cmd0, addr0}, {48'd0, 16'd9, 8'hF0});

    send(32'h00300010, 31);
    send(32'h00300010, 33);
    chk("len_err", {56'd0, err0}, 64'd2);
    chk("len_fcnt", {48'd0, fcnt0}, 64'd9);
    chk("len_code", {16'd0, code0}, 64'h0000000007FF);

    send(32'h00315A50, 24);
    chk("f24_rej_err", {56'd0, err0}, 64'd3);
    chk("f24_rej_fcnt", {48'd0, fcnt0}, 64'd9);
    chk("f24_acc_fcnt", {48'd0, fcnt1}, 64'd10);
    chk("f24_acc_code", {16'd0, code1}, 64'h0000005A57FF);
    chk("f24_acc_pd", {60'd0, pd1}, 64'hC);

    send(32'h00F00000, 32);
    chk("echo24_dut1", {32'd0, cap1}, {32'd0, 32'h00315A50});
    chk("echo_dut0", {32'd0, cap0}, {32'd0, 32'h00F0AAA0});
    chk("nop_fcnt1", {48'd0, fcnt1}, 64'd11);

    // Abort a frame after 21 bits with a clear pulse, then a full frame
    clr_pulse();
    DAC_CS = 1'b0;
    #5;
    for (int i = 31; i >= 11; i--) begin
      SPI_MOSI = (i == 21 || i == 20) ? 1'b1 : 1'b0;
      #5; SPI_SCK = 1'b1; #5; SPI_SCK = 1'b0;
    end
    #5;
    DAC_CLR = 1'b0;
    #5;
    DAC_CLR = 1'b1;
    #5;
    DAC_CS = 1'b1;
    #10;
    chk("abort_fcnt", {48'd0, fcnt0}, 64'd0);
    chk("abort_err", {56'd0, err0}, 64'd0);
    send(32'h00312340, 32);
    chk("after_abort_fcnt", {48'd0, fcnt0}, 64'd1);
    chk("after_abort_err", {56'd0, err0}, 64'd0);
    chk("after_abort_code", {16'd0, code0}, 64'h000000234000);
    chk("after_abort_echo", {32'd0, cap0}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_channel_model.md
DAC_SPI_CHANNEL_MODEL -- requirements
Module: dac_spi_channel_model

Interface
REQ-001 Parameter NCH, default 4: number of modelled DAC channels, range 1..15.
REQ-002 Parameter DATA_W, default 12: code width, range 8..16; the data field occupies frame bits [15:16-DATA_W].
REQ-003 Parameter ALLOW_24, default 0: when 1, 24-bit frames are also accepted.
REQ-004 SPI_SCK  in  1  serial clock; MOSI sampled on rising edge, DAC_OUT changes on falling edge.
REQ-005 DAC_CLR  in  1  reset DAC_CLR, asynchronous, active-low.
REQ-006 DAC_CS  in  1  frame select, active-low; a frame spans from the falling edge of DAC_CS to its rising edge.
REQ-007 SPI_MOSI  in  1  serial data, MSB first.
REQ-008 DAC_OUT  out  1  daisy-chain output carrying the previous accepted frame, MSB first.
REQ-009 dac_code  out  NCH*DATA_W  DAC register of every channel; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 pd_mask  out  NCH  per-channel power-down flags.
REQ-011 frame_cnt  out  16  count of accepted frames; wraps on overflow.
REQ-012 err_cnt  out  8  count of rejected frames; saturates at 255.
REQ-013 last_cmd / last_addr  out  4 / 4  command and address fields of the last accepted frame.

Function
REQ-014 Rising SPI_SCK with DAC_CS low and the frame armed: the 32-bit shift register shifts left and SPI_MOSI enters the LSB; the 6-bit bit counter increments and saturates at 63.
REQ-015 Falling DAC_CS with DAC_CLR high: arms the frame, clears the bit counter, and loads the echo register from the last accepted frame word.
REQ-016 Rising DAC_CS closes the frame; the frame is accepted only if the bit count is 32, or 24 when ALLOW_24=1; any other count increments err_cnt and changes no register.
REQ-017 Field extraction for an accepted frame: cmd = word[23:20], addr = word[19:16], data = word[15:16-DATA_W]; the LSBs below the data field and bits [31:24] are ignored.
REQ-018 Per-channel registers: an input register (DATA_W) and a DAC register (DATA_W); dac_code reflects the DAC registers only.
REQ-019 Command 0000: input[addr] <= data.
REQ-020 Command 0001: dac[addr] <= input[addr].
REQ-021 Command 0010: input[addr] <= data, then every channel performs dac <= input, using the new value for addr.
REQ-022 Command 0011: input[addr] <= dac[addr] <= data.
REQ-023 Command 0100: pd_mask[addr] <= 1; dac_code for that channel reads 0 while pd is set, and the stored DAC register is kept.
REQ-024 Commands 0001, 0010 and 0011 clear pd on every channel whose DAC register they update.
REQ-025 Command 1111 (no-op) and all other commands: no register change; the frame still counts as accepted.
REQ-026 addr 1111: the command applies to all NCH channels; any other addr >= NCH causes no register change, but the frame is still accepted.
REQ-027 On every accepted frame: frame_cnt increments; last_cmd/last_addr update; the full 32-bit word is stored for echo (24-bit frames are stored zero-extended).
REQ-028 DAC_OUT = echo[31] while DAC_CS is low; each falling SPI_SCK with DAC_CS low shifts echo left and fills with 0; DAC_OUT = 0 while DAC_CS is high.
REQ-029 SPI_SCK edges while DAC_CS is high are ignored.
REQ-030 DAC_CLR asserted mid-frame disarms the frame; its rising DAC_CS is then ignored and counts neither as accepted nor as an error.
REQ-031 A frame is armed only by a falling DAC_CS that occurs after DAC_CLR is released.
REQ-032 Simultaneous DAC_CLR fall and any other edge: reset wins.

Reset
REQ-033 While DAC_CLR is low: all input and DAC registers, pd_mask, frame_cnt, err_cnt, last_cmd, last_addr, the shift register, the echo register and the bit counter are 0; DAC_OUT = 0; the frame is disarmed.
REQ-034 Release of DAC_CLR is asynchronous; no edge is required before normal operation.

Verification
REQ-035 Write-update: frame 0x00_3_2_ABC_0 (cmd 0011, ch2, 0xABC) -> dac_code ch2 = 0xABC, frame_cnt = 1.
REQ-036 Staged update: frame 0x00_0_1_123_0, then 0x00_1_1_000_0 -> ch1 stays 0 after frame 1 and reads 0x123 after frame 2.
REQ-037 Broadcast: cmd 0011, addr F, data 0x7FF -> all NCH channels = 0x7FF; cmd 0100, addr F -> dac_code all 0, pd_mask all 1; cmd 0001, addr 0 -> ch0 = 0x7FF, pd_mask[0] = 0.
REQ-038 Length error: a 31-bit frame and a 33-bit frame -> err_cnt = 2, registers unchanged; with ALLOW_24=1 a 24-bit frame is accepted.
REQ-039 Echo: send frame A, then frame B -> DAC_OUT during frame B serialises A MSB first, 32 bits.
REQ-040 DAC_CLR pulse after bit 20 of a frame, followed by a complete frame -> the aborted frame is not counted, err_cnt = 0, frame_cnt = 1, and the registers reflect only the second frame.
